// File: rtl/mux_nt1_scan_pkg.sv
// Shared constants and helpers for the scanning N-to-1 multiplexer.
package mux_nt1_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Combinational round-robin search: next enabled channel strictly after cur,
// wrapping modulo CH. With a single enabled channel the answer is cur itself.
module rr_next_ch
  import mux_nt1_scan_pkg::*;
#(
  parameter int CH = 4,
  parameter int SW = 2
) (
  input  logic [SW-1:0] cur,
  input  logic [CH-1:0] mask,
  output logic [SW-1:0] nxt,
  output logic          wrapped,
  output logic          none
);

  logic [2*CH-1:0] dbl;
  logic [CH-1:0]   rot;
  int              k;
  int              sum;
  logic            found;

  always_comb begin
    dbl   = {mask, mask};
    // rot[i] is the enable of channel (cur+1+i) mod CH
    rot   = CH'(dbl >> (32'(cur) + 32'd1));
    k     = 0;
    found = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (!found && rot[i]) begin
        k     = i;
        found = 1'b1;
      end
    end
    sum = int'(cur) + 1 + k;
    if (sum >= CH) sum = sum - CH;
    nxt     = found ? SW'(sum) : cur;
    none    = ~found;
    wrapped = found && (nxt <= cur);
  end

endmodule

// File: rtl/mux_nt1_scan.sv
// Registered CH-channel W-bit multiplexer with manual select and an auto
// round-robin scan that dwells DWELL cycles on each enabled channel.
module mux_nt1_scan
  import mux_nt1_scan_pkg::*;
#(
  parameter int CH    = 4,
  parameter int W     = 4,
  parameter int DWELL = 50,
  localparam int SW   = clog2(CH),
  localparam int DW   = (DWELL > 1) ? clog2(DWELL) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [CH-1:0]   en_mask,
  input  logic            hold,
  input  logic [CH*W-1:0] din,
  output logic [W-1:0]    o,
  output logic [SW-1:0]   ch,
  output logic            o_vld,
  output logic            wrap
);

  logic [SW-1:0] ch_q, ch_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          mode_q;
  logic [W-1:0]  o_q, o_d;
  logic          o_vld_q, o_vld_d;
  logic          wrap_q, wrap_d;

  logic [SW-1:0] nxt;
  logic          wrapped;
  logic          none;

  rr_next_ch #(.CH(CH), .SW(SW)) u_rr (
    .cur     (ch_q),
    .mask    (en_mask),
    .nxt     (nxt),
    .wrapped (wrapped),
    .none    (none)
  );

  always_comb begin
    ch_d    = ch_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    o_d     = din[int'(ch_q)*W +: W];
    o_vld_d = (mode == MODE_AUTO) ? en_mask[ch_q] : 1'b1;

    if (hold) begin
      // frozen: ch and dwell keep their values, no wrap
    end else if (mode == MODE_MANUAL) begin
      dwell_d = '0;
      if (32'(s) < 32'(CH)) ch_d = s;
    end else if (mode_q == MODE_MANUAL) begin
      // first auto cycle: restart dwell, only leave ch if it is disabled
      dwell_d = '0;
      if (!en_mask[ch_q] && !none) begin
        ch_d   = nxt;
        wrap_d = wrapped;
      end
    end else if (none) begin
      dwell_d = '0;
    end else if (!en_mask[ch_q] || (dwell_q == DW'(DWELL - 1))) begin
      ch_d    = nxt;
      dwell_d = '0;
      wrap_d  = wrapped;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_MANUAL;
      o_q     <= '0;
      o_vld_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      mode_q  <= mode;
      o_q     <= o_d;
      o_vld_q <= o_vld_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o     = o_q;
  assign ch    = ch_q;
  assign o_vld = o_vld_q;
  assign wrap  = wrap_q;

endmodule
